l1_fill_sched: RTL

Fill scheduler between the per-stream L1 stream pointers and the L2. It collects cacheline requests from `nstreams` stream pointers and arbitrates them onto a single L2 request port. For each request it assigns the stream's next L1 line slot and keeps a bounded in-order FIFO of outstanding requests. Each L2 response is turned into a one-cycle fill pulse back to the owning stream pointer, together with the BRAM write address (stream id, line id).

---
 rtl/l1_fill_sched.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/l1_fill_sched.sv
`default_nettype none
// ============================================================================
// Module   : l1_fill_sched
// Purpose  : Fill scheduler between the per-stream L1 stream pointers and L2.
//            Arbitrates cacheline requests from nstreams stream pointers onto
//            one registered L2 request port. Each grant is tagged with the
//            stream's next L1 line slot. An in-order FIFO tracks outstanding
//            requests. Each L2 response turns into a one-cycle fill pulse
//            with the BRAM write address {sid, clid}.
// Config   : `L1_FILL_SCHED_RR_EN defined   -> round-robin arbitration
//            `L1_FILL_SCHED_RR_EN undefined -> fixed priority (lowest index)
// Ports    : clk, reset (async, active high)
//            i_srst_v    in  per-stream slot counter reset
//            i_clreq_v   in  per-stream request valid
//            i_clreq_r   out one-hot grant (combinational)
//            o_l2req_v/_r/_sid/_clid  registered L2 request channel
//            i_l2rsp_v   in  L2 response valid (in request order)
//            i_l2rsp_r   out response ready (something is outstanding)
//            o_clrsp_v   out one-hot fill-done pulse per stream
//            o_fill_v/_sid/_clid      BRAM write strobe and address
// Revision : 1.0 - initial release
// ============================================================================
module l1_fill_sched #(
  parameter int nstreams   = 8,
  parameter int ncl        = 16,
  parameter int max_out    = 4,
  parameter int sid_width  = $clog2(nstreams),
  parameter int clid_width = $clog2(ncl),
  parameter int out_width  = $clog2(max_out + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [nstreams-1:0]   i_srst_v,
  input  logic [nstreams-1:0]   i_clreq_v,
  output logic [nstreams-1:0]   i_clreq_r,
  output logic                  o_l2req_v,
  input  logic                  o_l2req_r,
  output logic [sid_width-1:0]  o_l2req_sid,
  output logic [clid_width-1:0] o_l2req_clid,
  input  logic                  i_l2rsp_v,
  output logic                  i_l2rsp_r,
  output logic [nstreams-1:0]   o_clrsp_v,
  output logic                  o_fill_v,
  output logic [sid_width-1:0]  o_fill_sid,
  output logic [clid_width-1:0] o_fill_clid
);

  localparam int                   ptr_width = (max_out > 1) ? $clog2(max_out) : 1;
  localparam logic [out_width-1:0] max_out_c = out_width'(max_out);
  localparam logic [ptr_width-1:0] ptr_last  = ptr_width'(max_out - 1);

  logic [nstreams-1:0]   elig;
  logic [nstreams-1:0]   grant;
  logic [sid_width-1:0]  gnt_sid;
  logic                  gnt_any;
  logic                  grant_ok;
  logic                  do_grant;
  logic                  rsp_acc;
  logic [nstreams-1:0]   fill_onehot;

  logic [out_width-1:0]  out_cnt;
  logic [clid_width-1:0] wr_clid [nstreams];

  // Outstanding FIFO; occupancy always equals out_cnt, so no separate count.
  logic [sid_width-1:0]  fifo_sid  [max_out];
  logic [clid_width-1:0] fifo_clid [max_out];
  logic [ptr_width-1:0]  wr_ptr;
  logic [ptr_width-1:0]  rd_ptr;

  // A stream being slot-reset this cycle must not be granted: its slot
  // counter is about to be forced back to 0.
  assign elig      = i_clreq_v & ~i_srst_v;
  assign grant_ok  = (~o_l2req_v | o_l2req_r) & (out_cnt < max_out_c) & ~reset;
  assign do_grant  = gnt_any & grant_ok;
  assign i_clreq_r = grant;
  assign i_l2rsp_r = (out_cnt != '0);
  assign rsp_acc   = i_l2rsp_v & i_l2rsp_r;

`ifdef L1_FILL_SCHED_RR_EN
  logic [sid_width-1:0] rr_ptr;

  // Search starts at rr_ptr and wraps; first eligible stream wins.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_sid = '0;
    idx     = 0;
    for (int i = 0; i < nstreams; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= nstreams) idx = idx - nstreams;
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_sid = sid_width'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (do_grant) begin
      rr_ptr <= (gnt_sid == sid_width'(nstreams - 1)) ? '0 : gnt_sid + 1'b1;
    end
  end
`else
  // Walk downwards so the lowest eligible index is the last one written.
  always_comb begin
    gnt_any = 1'b0;
    gnt_sid = '0;
    for (int i = nstreams - 1; i >= 0; i--) begin
      if (elig[i]) begin
        gnt_any = 1'b1;
        gnt_sid = sid_width'(i);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (do_grant) grant[gnt_sid] = 1'b1;
  end

  always_comb begin
    fill_onehot = '0;
    fill_onehot[fifo_sid[rd_ptr]] = 1'b1;
  end

  // Per-stream line slot counters; wrap relies on ncl being a power of two.
  for (genvar s = 0; s < nstreams; s++) begin : g_slot
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_clid[s] <= '0;
      end else if (i_srst_v[s]) begin
        wr_clid[s] <= '0;
      end else if (grant[s]) begin
        wr_clid[s] <= wr_clid[s] + 1'b1;
      end
    end
  end

  // FIFO payload needs no reset; validity is carried by the pointers.
  always_ff @(posedge clk) begin
    if (do_grant) begin
      fifo_sid[wr_ptr]  <= gnt_sid;
      fifo_clid[wr_ptr] <= wr_clid[gnt_sid];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_l2req_v    <= 1'b0;
      o_l2req_sid  <= '0;
      o_l2req_clid <= '0;
      out_cnt      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fill_v     <= 1'b0;
      o_fill_sid   <= '0;
      o_fill_clid  <= '0;
      o_clrsp_v    <= '0;
    end else begin
      if (do_grant) begin
        o_l2req_v    <= 1'b1;
        o_l2req_sid  <= gnt_sid;
        o_l2req_clid <= wr_clid[gnt_sid];
        wr_ptr       <= (wr_ptr == ptr_last) ? '0 : wr_ptr + 1'b1;
      end else if (o_l2req_r) begin
        o_l2req_v <= 1'b0;
      end

      case ({do_grant, rsp_acc})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase

      o_fill_v <= rsp_acc;
      if (rsp_acc) begin
        o_fill_sid  <= fifo_sid[rd_ptr];
        o_fill_clid <= fifo_clid[rd_ptr];
        o_clrsp_v   <= fill_onehot;
        rd_ptr      <= (rd_ptr == ptr_last) ? '0 : rd_ptr + 1'b1;
      end else begin
        o_clrsp_v   <= '0;
      end
    end
  end

endmodule
`default_nettype wire
